lb_window_seq_ctrl: RTL and testbench
=====================================

Name: lb_window_seq_ctrl

Overview:
- Frame sequencer for the 4-line-buffer 3x3 window generator.
- On start, fetches one frame of pixels in raster order from the image BRAM (1-cycle read latency) and streams them to the window generator under a valid/ready handshake.
- Drives the one-hot line-buffer write select and the three-hot read select.
- Flags which streamed pixels complete a valid 3-row window (row >= 2).

Parameters:
IMG_W, 400, pixels per line (>= 3)
IMG_H, 400, lines per frame (>= 3)
PIX_W, 4, pixel width in bits
ADDR_W, 18, BRAM address width; must satisfy 2^ADDR_W >= IMG_W*IMG_H

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
start  in  1  begin frame; sampled only in IDLE
busy  out  1  high from cycle after accepted start until done cycle inclusive
done  out  1  one-cycle pulse when last pixel of frame transferred
mem_rd_en  out  1  BRAM read strobe
mem_addr  out  ADDR_W  BRAM read address
mem_rdata  in  PIX_W  BRAM data, valid the cycle after mem_rd_en
pix_out  out  PIX_W  pixel to window generator
pix_valid  out  1  pix_out valid
out_ready  in  1  window generator accepts; transfer = pix_valid & out_ready
wr_sel  out  4  one-hot line buffer written by current pix_out: bit (out_row mod 4)
rd_sel  out  4  complement of wr_sel (three-hot)
out_row  out  9  row of current pix_out, 0..IMG_H-1
out_col  out  9  column of current pix_out, 0..IMG_W-1
win_valid  out  1  pix_valid & (out_row >= 2)
line_end  out  1  pix_valid & (out_col == IMG_W-1)

Behaviour:
- Reset values: busy=0, done=0, mem_rd_en=0, mem_addr=0, pix_out=0, pix_valid=0, out_row=0, out_col=0, wr_sel=4'b0001, rd_sel=4'b1110, win_valid=0, line_end=0.
- Reset also clears FSM, fetch counters, FIFO and in-flight flag. Reset mid-frame aborts: in-flight BRAM data is discarded, no done pulse.
- FSM states:
  - IDLE: start=1 -> FETCH.
  - FETCH: issues reads. After the read of address IMG_W*IMG_H-1 -> DRAIN.
  - DRAIN: issues no reads; waits for final transfer -> IDLE, done=1 for that one cycle.
- start while busy: ignored.
- Fetch side:
  - Issue a read (mem_rd_en=1, mem_addr=fetch_addr, fetch_addr+1) when state==FETCH and fifo_count + inflight < 3.
  - inflight = registered mem_rd_en.
  - mem_rdata is pushed into a 3-entry FIFO on the edge ending the cycle after the read.
- Output side:
  - pix_valid = FIFO non-empty; pix_out = FIFO head.
  - Pop on transfer.
  - On transfer: out_col+1; at IMG_W-1, out_col wraps to 0 and out_row+1.
  - wr_sel/rd_sel follow the new out_row in the same cycle.
  - pix_out, out_row and out_col hold stable while pix_valid=1 and out_ready=0.
- Latency: start high in cycle T -> mem_rd_en=1, addr 0 in T+1 -> mem_rdata in T+2 -> pix_valid=1, pix_out=mem[0] in T+3.
- Throughput: with out_ready held high, one transfer per cycle sustained (no bubbles after the first pixel).
- FIFO never overflows. Push and pop in the same cycle leave fifo_count unchanged.
- Line-buffer rotation: row r is written to buffer r mod 4. Rows r-1..r-3 are read from the other three. Rotation wraps 3->0.
- Simultaneous events:
  - done cycle and start=1: start ignored (state not yet IDLE).
  - Next frame restarts at out_row=0, wr_sel=0001.
- fetch_addr resets to 0 at each accepted start.

Test Plan:
1. IMG_W=8, IMG_H=6, mem[a]=a[3:0], out_ready=1, start pulse at T -> mem_rd_en first high T+1, pix_valid T+3 with pix_out 0, then 48 consecutive transfers values 0..15 repeating; done single pulse at T+50; busy low T+51.
2. Same config; check per-row selects -> row 0 wr_sel=0001/rd_sel=1110, row 3 wr_sel=1000, row 4 wr_sel=0001; win_valid low for first 16 transfers, high for remaining 32; line_end high on out_col=7 only.
3. Backpressure: out_ready low for 5 cycles at pixel 10 -> pix_out=10, out_row=1, out_col=2 held; mem_rd_en drops after FIFO fills (count+inflight=3); no data lost or duplicated; sequence resumes 10,11,...
4. Random out_ready (50%) over full frame -> transferred sequence equals mem[0..47] in order, exactly 48 transfers, one done pulse.
5. Reset asserted at transfer 20 for 1 cycle -> next cycle all outputs at reset values; late mem_rdata ignored; new start replays from addr 0, pix_out 0.
6. start held high through whole frame and during done cycle -> single frame only during busy; a new frame begins only from IDLE (start sampled cycle after done).

Source files
------------

// File: rtl/lb_window_seq_ctrl.sv
// ---------------------------------------------------------------------------
// lb_window_seq_ctrl
// Frame sequencer for the 4-line-buffer 3x3 window generator. On start it
// reads one frame in raster order from an image BRAM (1-cycle read latency),
// buffers the returned pixels in a 3-entry FIFO and streams them to the
// window generator under a valid/ready handshake. It also drives the line
// buffer write/read selects and flags pixels that complete a 3-row window.
//
// Ports:
//   clk, reset           clock, synchronous active-high reset
//   start                begin a frame (sampled only while idle)
//   busy, done           frame in progress / one-cycle end-of-frame pulse
//   mem_rd_en, mem_addr  BRAM read strobe and address
//   mem_rdata            BRAM data, valid the cycle after mem_rd_en
//   pix_out, pix_valid   pixel stream to the window generator
//   out_ready            window generator accepts the current pixel
//   wr_sel, rd_sel       one-hot line buffer write select, three-hot read select
//   out_row, out_col     raster position of pix_out
//   win_valid, line_end  pixel completes a 3-row window / last pixel of a line
// ---------------------------------------------------------------------------
module lb_window_seq_ctrl #(
  parameter int IMG_W  = 400,
  parameter int IMG_H  = 400,
  parameter int PIX_W  = 4,
  parameter int ADDR_W = 18
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [PIX_W-1:0]  mem_rdata,
  output logic [PIX_W-1:0]  pix_out,
  output logic              pix_valid,
  input  logic              out_ready,
  output logic [3:0]        wr_sel,
  output logic [3:0]        rd_sel,
  output logic [8:0]        out_row,
  output logic [8:0]        out_col,
  output logic              win_valid,
  output logic              line_end
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMG_W * IMG_H - 1);
  localparam logic [8:0]        LAST_COL  = 9'(IMG_W - 1);
  localparam logic [8:0]        LAST_ROW  = 9'(IMG_H - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t              state_q;
  logic                busy_q;
  logic                rd_en_q, rd_en_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W-1:0]   fetch_addr_q, fetch_addr_d;
  logic                inflight_q;
  logic [PIX_W-1:0]    fifo_q [3];
  logic [PIX_W-1:0]    fifo_d [3];
  logic [1:0]          count_q, count_d;
  logic                valid_q, valid_d;
  logic [8:0]          row_q, row_d;
  logic [8:0]          col_q, col_d;
  logic [3:0]          wr_sel_q, wr_sel_d;
  logic                win_valid_q, win_valid_d;
  logic                line_end_q, line_end_d;

  logic                transfer_s;
  logic                last_pix_s;
  logic                start_acc_s;
  logic                fetch_done_s;
  logic                frame_end_s;
  logic                fetch_next_s;
  logic [ADDR_W-1:0]   fetch_base_s;
  logic [1:0]          cnt_pop_s;

  // Next-state computation for fetch side, FIFO and output position.
  always_comb begin
    transfer_s   = valid_q & out_ready;
    last_pix_s   = (row_q == LAST_ROW) && (col_q == LAST_COL);
    start_acc_s  = (state_q == ST_IDLE) && start;
    fetch_done_s = (state_q == ST_FETCH) && rd_en_q && (addr_q == LAST_ADDR);
    frame_end_s  = (state_q == ST_DRAIN) && transfer_s && last_pix_s;
    // Reads are decided one cycle ahead so mem_rd_en can be a register:
    // fetch_next_s says the FSM will be in FETCH during the next cycle.
    fetch_next_s = start_acc_s || ((state_q == ST_FETCH) && !fetch_done_s);
    fetch_base_s = start_acc_s ? '0 : fetch_addr_q;

    // FIFO is a shift register with the head in entry 0, so pix_out is a
    // plain flop and stays put while the consumer stalls.
    cnt_pop_s = count_q - {1'b0, transfer_s};
    fifo_d    = fifo_q;
    if (transfer_s) begin
      fifo_d[0] = fifo_q[1];
      fifo_d[1] = fifo_q[2];
    end else begin
      fifo_d[0] = fifo_q[0];
      fifo_d[1] = fifo_q[1];
    end
    if (inflight_q) begin
      case (cnt_pop_s)
        2'd0:    fifo_d[0] = mem_rdata;
        2'd1:    fifo_d[1] = mem_rdata;
        2'd2:    fifo_d[2] = mem_rdata;
        default: fifo_d[2] = fifo_q[2];
      endcase
    end else begin
      fifo_d[2] = fifo_d[2];
    end
    count_d = cnt_pop_s + {1'b0, inflight_q};
    valid_d = (count_d != 2'd0);

    // Next cycle's in-flight read equals this cycle's read, so the FIFO
    // occupancy plus that read bounds the reads we may issue.
    rd_en_d = fetch_next_s && (({1'b0, count_d} + {2'b0, rd_en_q}) < 3'd3);
    if (rd_en_d) begin
      addr_d       = fetch_base_s;
      fetch_addr_d = fetch_base_s + ADDR_W'(1);
    end else begin
      addr_d       = addr_q;
      fetch_addr_d = fetch_base_s;
    end

    // Raster position of the head pixel; wraps to 0,0 after the last pixel.
    if (start_acc_s) begin
      row_d = 9'd0;
      col_d = 9'd0;
    end else if (transfer_s) begin
      if (col_q == LAST_COL) begin
        col_d = 9'd0;
        row_d = (row_q == LAST_ROW) ? 9'd0 : row_q + 9'd1;
      end else begin
        col_d = col_q + 9'd1;
        row_d = row_q;
      end
    end else begin
      row_d = row_q;
      col_d = col_q;
    end

    wr_sel_d    = 4'b0001 << row_d[1:0];
    win_valid_d = valid_d && (row_d >= 9'd2);
    line_end_d  = valid_d && (col_d == LAST_COL);
  end

  // FSM and all output/state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      busy_q       <= 1'b0;
      rd_en_q      <= 1'b0;
      addr_q       <= '0;
      fetch_addr_q <= '0;
      inflight_q   <= 1'b0;
      fifo_q[0]    <= '0;
      fifo_q[1]    <= '0;
      fifo_q[2]    <= '0;
      count_q      <= 2'd0;
      valid_q      <= 1'b0;
      row_q        <= 9'd0;
      col_q        <= 9'd0;
      wr_sel_q     <= 4'b0001;
      win_valid_q  <= 1'b0;
      line_end_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q <= ST_FETCH;
            busy_q  <= 1'b1;
          end
        end
        ST_FETCH: begin
          if (fetch_done_s) begin
            state_q <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (frame_end_s) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
      rd_en_q      <= rd_en_d;
      addr_q       <= addr_d;
      fetch_addr_q <= fetch_addr_d;
      inflight_q   <= rd_en_q;
      fifo_q       <= fifo_d;
      count_q      <= count_d;
      valid_q      <= valid_d;
      row_q        <= row_d;
      col_q        <= col_d;
      wr_sel_q     <= wr_sel_d;
      win_valid_q  <= win_valid_d;
      line_end_q   <= line_end_d;
    end
  end

  assign busy      = busy_q;
  // done must coincide with the final transfer, which depends on out_ready
  // in the same cycle, so it cannot be registered.
  assign done      = frame_end_s;
  assign mem_rd_en = rd_en_q;
  assign mem_addr  = addr_q;
  assign pix_out   = fifo_q[0];
  assign pix_valid = valid_q;
  assign wr_sel    = wr_sel_q;
  assign rd_sel    = ~wr_sel_q;
  assign out_row   = row_q;
  assign out_col   = col_q;
  assign win_valid = win_valid_q;
  assign line_end  = line_end_q;

endmodule

// File: tb/tb_lb_window_seq_ctrl.sv
module tb_lb_window_seq_ctrl;

  localparam int W    = 8;
  localparam int H    = 6;
  localparam int PW   = 4;
  localparam int AW   = 6;
  localparam int NPIX = W * H;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          out_ready = 1'b0;
  logic [PW-1:0] mem_rdata = '0;
  logic          busy, done, mem_rd_en, pix_valid, win_valid, line_end;
  logic [AW-1:0] mem_addr;
  logic [PW-1:0] pix_out;
  logic [3:0]    wr_sel, rd_sel;
  logic [8:0]    out_row, out_col;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0] pix;
    int         row;
    int         col;
  } exp_t;
  exp_t sb_q[$];

  lb_window_seq_ctrl #(.IMG_W(W), .IMG_H(H), .PIX_W(PW), .ADDR_W(AW)) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .pix_out(pix_out), .pix_valid(pix_valid), .out_ready(out_ready),
    .wr_sel(wr_sel), .rd_sel(rd_sel), .out_row(out_row), .out_col(out_col),
    .win_valid(win_valid), .line_end(line_end)
  );

  always #5 clk = ~clk;

  // Image BRAM model: mem[a] = a[3:0], one cycle read latency.
  always @(posedge clk) begin
    if (mem_rd_en) mem_rdata <= mem_addr[3:0];
  end

  // One clock cycle: inputs change just after the edge, outputs sampled mid-cycle.
  task automatic step(input logic rdy, input logic st, input logic rst);
    @(posedge clk);
    #1;
    out_ready = rdy;
    start     = st;
    reset     = rst;
    @(negedge clk);
  endtask

  task automatic sb_fill();
    exp_t e;
    logic [AW-1:0] av;
    sb_q.delete();
    for (int a = 0; a < NPIX; a++) begin
      av    = AW'(a);
      e.pix = av[3:0];
      e.row = a / W;
      e.col = a % W;
      sb_q.push_back(e);
    end
  endtask

  task automatic test_reset();
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    checks++;
    if ({busy, done, mem_rd_en, pix_valid, win_valid, line_end} !== 6'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b expected 000000", {busy, done, mem_rd_en, pix_valid, win_valid, line_end});
    end
    checks++;
    if ({mem_addr, pix_out, out_row, out_col} !== {AW'(0), 4'h0, 9'd0, 9'd0}) begin
      errors++;
      $display("FAIL reset_values: addr %0d pix %0h row %0d col %0d expected all 0", mem_addr, pix_out, out_row, out_col);
    end
    checks++;
    if (wr_sel !== 4'b0001 || rd_sel !== 4'b1110) begin
      errors++;
      $display("FAIL reset_sel: wr %b rd %b expected 0001/1110", wr_sel, rd_sel);
    end
  endtask

  task automatic test_latency_stream();
    exp_t e;
    int first_rd = -1, first_valid = -1, done_cnt = 0, done_cyc = -1, nx = 0, last_x = -1;
    logic busy0, busy50, busy51;
    sb_fill();
    step(1'b1, 1'b1, 1'b0);
    busy0 = busy;
    for (int c = 1; c <= 60; c++) begin
      step(1'b1, 1'b0, 1'b0);
      if (mem_rd_en && first_rd < 0) first_rd = c;
      if (pix_valid && first_valid < 0) first_valid = c;
      if (done) begin done_cnt++; done_cyc = c; end
      if (c == 50) busy50 = busy;
      if (c == 51) busy51 = busy;
      if (pix_valid && out_ready) begin
        nx++;
        last_x = c;
        checks++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL lat_extra_xfer: pix %0h at cycle %0d, none expected", pix_out, c);
        end else begin
          e = sb_q.pop_front();
          if (pix_out !== e.pix || out_row !== 9'(e.row) || out_col !== 9'(e.col)) begin
            errors++;
            $display("FAIL lat_data: got %0h r%0d c%0d expected %0h r%0d c%0d", pix_out, out_row, out_col, e.pix, e.row, e.col);
          end
        end
      end
    end
    checks++;
    if (busy0 !== 1'b0) begin errors++; $display("FAIL lat_busy_T: got %b expected 0", busy0); end
    checks++;
    if (first_rd != 1) begin errors++; $display("FAIL lat_first_rd: got cycle %0d expected 1", first_rd); end
    checks++;
    if (first_valid != 3) begin errors++; $display("FAIL lat_first_valid: got cycle %0d expected 3", first_valid); end
    checks++;
    if (nx != NPIX || last_x != 50) begin errors++; $display("FAIL lat_xfers: got %0d ending %0d expected 48 ending 50", nx, last_x); end
    checks++;
    if (done_cnt != 1 || done_cyc != 50) begin errors++; $display("FAIL lat_done: got %0d pulses at %0d expected 1 at 50", done_cnt, done_cyc); end
    checks++;
    if (busy50 !== 1'b1 || busy51 !== 1'b0) begin errors++; $display("FAIL lat_busy_end: got %b%b expected 10", busy50, busy51); end
  endtask

  task automatic test_selects();
    exp_t e;
    logic [3:0] one, exp_wr;
    int win_cnt = 0, le_cnt = 0;
    one = 4'b0001;
    sb_fill();
    step(1'b1, 1'b1, 1'b0);
    for (int c = 1; c <= 60; c++) begin
      step(1'b1, 1'b0, 1'b0);
      if (pix_valid && out_ready && sb_q.size() > 0) begin
        e = sb_q.pop_front();
        exp_wr = one << (e.row % 4);
        if (win_valid) win_cnt++;
        if (line_end) le_cnt++;
        checks++;
        if (wr_sel !== exp_wr || rd_sel !== ~exp_wr) begin
          errors++;
          $display("FAIL sel_row%0d: wr %b rd %b expected %b/%b", e.row, wr_sel, rd_sel, exp_wr, ~exp_wr);
        end
        checks++;
        if (win_valid !== (e.row >= 2) || line_end !== (e.col == W - 1)) begin
          errors++;
          $display("FAIL sel_flags r%0d c%0d: win %b le %b expected %b %b", e.row, e.col, win_valid, line_end, e.row >= 2, e.col == W - 1);
        end
      end else if (!pix_valid) begin
        checks++;
        if (win_valid !== 1'b0 || line_end !== 1'b0) begin
          errors++;
          $display("FAIL sel_idle_flags: win %b le %b expected 0 0 at cycle %0d", win_valid, line_end, c);
        end
      end
    end
    checks++;
    if (win_cnt != 32 || le_cnt != H || sb_q.size() != 0) begin
      errors++;
      $display("FAIL sel_counts: win %0d le %0d left %0d expected 32 6 0", win_cnt, le_cnt, sb_q.size());
    end
  endtask

  task automatic test_backpressure();
    exp_t e;
    logic rdy;
    int nx = 0, stall_left = 5, k, rd_cnt = 0, done_cnt = 0, post = -1;
    sb_fill();
    for (int c = 0; c < 200; c++) begin
      rdy = 1'b1;
      k = -1;
      if (nx == 10 && stall_left > 0) begin
        rdy = 1'b0;
        k = 5 - stall_left;
        stall_left--;
      end
      step(rdy, (c == 0), 1'b0);
      if (mem_rd_en) rd_cnt++;
      if (done) begin done_cnt++; post = c + 4; end
      if (k >= 0) begin
        checks++;
        if (pix_valid !== 1'b1 || pix_out !== 4'hA || out_row !== 9'd1 || out_col !== 9'd2) begin
          errors++;
          $display("FAIL bp_hold%0d: v %b pix %0h r%0d c%0d expected 1 a r1 c2", k, pix_valid, pix_out, out_row, out_col);
        end
        if (k >= 2) begin
          checks++;
          if (mem_rd_en !== 1'b0) begin errors++; $display("FAIL bp_rd_stop%0d: got %b expected 0", k, mem_rd_en); end
        end
      end
      if (pix_valid && out_ready) begin
        nx++;
        checks++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL bp_extra_xfer: pix %0h, none expected", pix_out);
        end else begin
          e = sb_q.pop_front();
          if (pix_out !== e.pix || out_row !== 9'(e.row) || out_col !== 9'(e.col)) begin
            errors++;
            $display("FAIL bp_data: got %0h r%0d c%0d expected %0h r%0d c%0d", pix_out, out_row, out_col, e.pix, e.row, e.col);
          end
        end
      end
      if (c == post) break;
    end
    checks++;
    if (nx != NPIX || rd_cnt != NPIX || done_cnt != 1 || sb_q.size() != 0) begin
      errors++;
      $display("FAIL bp_totals: xfers %0d reads %0d done %0d left %0d expected 48 48 1 0", nx, rd_cnt, done_cnt, sb_q.size());
    end
  endtask

  task automatic test_random_ready();
    exp_t e;
    int nx = 0, done_cnt = 0, post = -1;
    sb_fill();
    for (int c = 0; c < 600; c++) begin
      step(1'($urandom_range(0, 1)), (c == 0), 1'b0);
      if (done) begin done_cnt++; if (post < 0) post = c + 5; end
      if (pix_valid && out_ready) begin
        nx++;
        checks++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL rnd_extra_xfer: pix %0h, none expected", pix_out);
        end else begin
          e = sb_q.pop_front();
          if (pix_out !== e.pix || out_row !== 9'(e.row) || out_col !== 9'(e.col)) begin
            errors++;
            $display("FAIL rnd_data: got %0h r%0d c%0d expected %0h r%0d c%0d", pix_out, out_row, out_col, e.pix, e.row, e.col);
          end
        end
      end
      if (c == post) break;
    end
    checks++;
    if (nx != NPIX || done_cnt != 1 || sb_q.size() != 0) begin
      errors++;
      $display("FAIL rnd_totals: xfers %0d done %0d left %0d expected 48 1 0", nx, done_cnt, sb_q.size());
    end
  endtask

  task automatic test_reset_abort();
    exp_t e;
    int nx = 0, done_cnt = 0, post = -1, bad = 0;
    sb_fill();
    for (int c = 0; c < 100 && nx < 20; c++) begin
      step(1'b1, (c == 0), 1'b0);
      if (pix_valid && out_ready && sb_q.size() > 0) begin
        nx++;
        e = sb_q.pop_front();
        checks++;
        if (pix_out !== e.pix) begin errors++; $display("FAIL abort_pre_data: got %0h expected %0h", pix_out, e.pix); end
      end
    end
    checks++;
    if (nx != 20) begin errors++; $display("FAIL abort_reach20: got %0d transfers expected 20", nx); end
    step(1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0);
    checks++;
    if ({busy, done, mem_rd_en, pix_valid, win_valid, line_end} !== 6'b0 ||
        {mem_addr, pix_out, out_row, out_col} !== {AW'(0), 4'h0, 9'd0, 9'd0} ||
        wr_sel !== 4'b0001 || rd_sel !== 4'b1110) begin
      errors++;
      $display("FAIL abort_reset_vals: flags %b addr %0d pix %0h r%0d c%0d wr %b rd %b",
               {busy, done, mem_rd_en, pix_valid, win_valid, line_end}, mem_addr, pix_out, out_row, out_col, wr_sel, rd_sel);
    end
    for (int c = 0; c < 6; c++) begin
      step(1'b1, 1'b0, 1'b0);
      if (pix_valid || mem_rd_en || busy || done) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL abort_quiet: got %0d active cycles expected 0", bad); end
    sb_fill();
    nx = 0;
    for (int c = 0; c < 200; c++) begin
      step(1'b1, (c == 0), 1'b0);
      if (done) begin done_cnt++; if (post < 0) post = c + 3; end
      if (pix_valid && out_ready) begin
        nx++;
        checks++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL abort_extra_xfer: pix %0h, none expected", pix_out);
        end else begin
          e = sb_q.pop_front();
          if (pix_out !== e.pix || out_row !== 9'(e.row) || out_col !== 9'(e.col)) begin
            errors++;
            $display("FAIL abort_replay: got %0h r%0d c%0d expected %0h r%0d c%0d", pix_out, out_row, out_col, e.pix, e.row, e.col);
          end
        end
      end
      if (c == post) break;
    end
    checks++;
    if (nx != NPIX || done_cnt != 1) begin errors++; $display("FAIL abort_totals: xfers %0d done %0d expected 48 1", nx, done_cnt); end
  endtask

  task automatic test_start_held();
    exp_t e;
    int done_cnt = 0, done_cyc = -1, rd_cnt = 0, nx = 0;
    logic b51, b52, r52;
    logic [AW-1:0] a52;
    sb_fill();
    for (int c = 0; c <= 54; c++) begin
      step(1'b1, 1'b1, 1'b0);
      if (done) begin done_cnt++; done_cyc = c; end
      if (mem_rd_en && c <= 51) rd_cnt++;
      if (c == 51) b51 = busy;
      if (c == 52) begin b52 = busy; r52 = mem_rd_en; a52 = mem_addr; end
      if (pix_valid && out_ready && c <= 50 && sb_q.size() > 0) begin
        nx++;
        e = sb_q.pop_front();
        checks++;
        if (pix_out !== e.pix) begin errors++; $display("FAIL held_data: got %0h expected %0h", pix_out, e.pix); end
      end
      if (c == 54) begin
        checks++;
        if (pix_valid !== 1'b1 || pix_out !== 4'h0 || out_row !== 9'd0 || out_col !== 9'd0 || wr_sel !== 4'b0001) begin
          errors++;
          $display("FAIL held_frame2_first: v %b pix %0h r%0d c%0d wr %b expected 1 0 r0 c0 0001", pix_valid, pix_out, out_row, out_col, wr_sel);
        end
      end
    end
    checks++;
    if (done_cnt != 1 || done_cyc != 50) begin errors++; $display("FAIL held_done: got %0d pulses at %0d expected 1 at 50", done_cnt, done_cyc); end
    checks++;
    if (rd_cnt != NPIX || nx != NPIX) begin errors++; $display("FAIL held_frame1: reads %0d xfers %0d expected 48 48", rd_cnt, nx); end
    checks++;
    if (b51 !== 1'b0 || b52 !== 1'b1 || r52 !== 1'b1 || a52 !== AW'(0)) begin
      errors++;
      $display("FAIL held_restart: busy51 %b busy52 %b rd52 %b addr52 %0d expected 0 1 1 0", b51, b52, r52, a52);
    end
  endtask

  initial begin
    test_reset();
    test_latency_stream();
    test_selects();
    test_backpressure();
    test_random_ready();
    test_reset_abort();
    test_start_held();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
